// File: rtl/sonar_tx_array.sv
// sonar_tx_array: multi-channel phased-array ultrasound transmitter.
// A shared frame timer starts every channel once per TX period; each channel
// waits its own delay, then plays a PAT_W-bit phase-coded, masked carrier burst.
// Optional feature macro: SONAR_TX_DEADTIME_EN adds complementary wave_n outputs
// with DEAD cycles of dead time around every edge (H-bridge drive).
module sonar_tx_array #(
    parameter int N_CH  = 4,
    parameter int PAT_W = 16,
    parameter int HP_W  = 16,
    parameter int DLY_W = 16
`ifdef SONAR_TX_DEADTIME_EN
    ,
    parameter int DEAD  = 2
`endif
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic [HP_W-1:0]       half_period,
    input  logic [PAT_W-1:0]      pattern,
    input  logic [PAT_W-1:0]      mask,
    input  logic [15:0]           pulse_len,
    input  logic [31:0]           tx_period,
    input  logic [N_CH*DLY_W-1:0] ch_delay,
    input  logic [N_CH-1:0]       ch_enable,
    output logic [N_CH-1:0]       wave,
`ifdef SONAR_TX_DEADTIME_EN
    output logic [N_CH-1:0]       wave_n,
`endif
    output logic                  frame_sync,
    output logic                  busy
);

    // Bit-cycle counter must hold 2*hp*pl without overflow.
    localparam int CW = HP_W + 17;
    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    typedef enum logic [1:0] {IDLE, DELAY, BURST} state_t;

    logic [31:0]      frame_cnt;
    logic             frame_start;
    logic [HP_W-1:0]  hp_sh;
    logic [PAT_W-1:0] pat_sh;
    logic [PAT_W-1:0] mask_sh;
    logic [15:0]      pl_sh;
    logic [HP_W-1:0]  hp_eff;
    logic [15:0]      pl_eff;
    logic [HP_W-1:0]  half_last;
    logic [CW-1:0]    bit_last;
    logic [N_CH-1:0]  active;

    // The all-ones idle value is >= any tx_period, so the first enabled edge wraps.
    assign frame_start = enable && (frame_cnt >= tx_period);

    // Zero half_period / pulse_len behave as 1.
    assign hp_eff    = (hp_sh == '0) ? HP_W'(1) : hp_sh;
    assign pl_eff    = (pl_sh == '0) ? 16'd1 : pl_sh;
    assign half_last = hp_eff - HP_W'(1);
    assign bit_last  = ((CW'(hp_eff) * CW'(pl_eff)) << 1) - CW'(1);

    assign busy = |active;

    // Frame timer, frame_sync strobe and per-frame shadow capture.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rstn) begin
            frame_cnt  <= '1;
            frame_sync <= 1'b0;
            hp_sh      <= '0;
            pat_sh     <= '0;
            mask_sh    <= '0;
            pl_sh      <= '0;
        end else if (!enable) begin
            frame_cnt  <= '1;
            frame_sync <= 1'b0;
        end else begin
            frame_sync <= frame_start;
            if (frame_start) begin
                frame_cnt <= '0;
                hp_sh     <= half_period;
                pat_sh    <= pattern;
                mask_sh   <= mask;
                pl_sh     <= pulse_len;
            end else begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           state;
        logic [DLY_W-1:0] dly_cnt;
        logic [HP_W-1:0]  half_cnt;
        logic [CW-1:0]    bit_cnt;
        logic [BW-1:0]    bit_idx;
        logic             phase;
        logic             raw_p;
        logic             wave_q;

        assign active[i] = (state != IDLE);
        assign wave[i]   = wave_q;

        // Carrier level this channel would drive for the current cycle.
        always_comb begin
            // NOTE: default first so no path through this block infers a latch.
            raw_p = 1'b0;
            if (enable && state == BURST)
                raw_p = (pat_sh[bit_idx] ^ phase) & mask_sh[bit_idx];
        end

        // Channel sequencer: IDLE -> DELAY -> BURST, restarted by every frame.
        // ch_delay / ch_enable are consumed only at the capture edge, so loading
        // them straight into the counter is the same as reading their shadow.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                state    <= IDLE;
                dly_cnt  <= '0;
                half_cnt <= '0;
                bit_cnt  <= '0;
                bit_idx  <= '0;
                phase    <= 1'b0;
            end else if (!enable) begin
                state <= IDLE;
            end else if (frame_start) begin
                half_cnt <= '0;
                bit_cnt  <= '0;
                bit_idx  <= '0;
                phase    <= 1'b0;
                dly_cnt  <= ch_delay[i*DLY_W +: DLY_W];
                if (!ch_enable[i])
                    state <= IDLE;
                else if (ch_delay[i*DLY_W +: DLY_W] == '0)
                    state <= BURST;
                else
                    state <= DELAY;
            end else begin
                case (state)
                    DELAY: begin
                        // Leaving at count 1 makes BURST begin exactly d cycles after the frame.
                        if (dly_cnt == DLY_W'(1)) state <= BURST;
                        dly_cnt <= dly_cnt - 1'b1;
                    end
                    BURST: begin
                        if (half_cnt == half_last) begin
                            half_cnt <= '0;
                            phase    <= ~phase;
                        end else begin
                            half_cnt <= half_cnt + 1'b1;
                        end
                        if (bit_cnt == bit_last) begin
                            bit_cnt <= '0;
                            if (bit_idx == BW'(PAT_W - 1)) state <= IDLE;
                            else bit_idx <= bit_idx + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

`ifdef SONAR_TX_DEADTIME_EN
        localparam int DW = (DEAD > 1) ? $clog2(DEAD + 1) : 1;
        logic          raw_n;
        logic          tgt_p;
        logic          tgt_n;
        logic [DW-1:0] dead_cnt;
        logic          wave_n_q;

        assign raw_n     = enable && state == BURST &&
                           (~(pat_sh[bit_idx] ^ phase) & mask_sh[bit_idx]);
        assign wave_n[i] = wave_n_q;

        // Dead-time insertion: any change of the leg pair blanks both legs DEAD cycles.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                tgt_p    <= 1'b0;
                tgt_n    <= 1'b0;
                dead_cnt <= '0;
                wave_q   <= 1'b0;
                wave_n_q <= 1'b0;
            end else begin
                tgt_p <= raw_p;
                tgt_n <= raw_n;
                if ({raw_p, raw_n} != {tgt_p, tgt_n}) begin
                    dead_cnt <= DW'(DEAD);
                    wave_q   <= 1'b0;
                    wave_n_q <= 1'b0;
                end else if (dead_cnt > DW'(1)) begin
                    dead_cnt <= dead_cnt - 1'b1;
                    wave_q   <= 1'b0;
                    wave_n_q <= 1'b0;
                end else begin
                    dead_cnt <= '0;
                    wave_q   <= raw_p;
                    wave_n_q <= raw_n;
                end
            end
        end
`else
        // Registered carrier output.
        always_ff @(posedge clk) begin
            if (!rstn) wave_q <= 1'b0;
            else       wave_q <= raw_p;
        end
`endif
    end

endmodule
